serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock.
- Built around one full-subtractor cell (difference = x^y^brw; borrow = (~x&y)|(y&brw)|(~x&brw)) plus a registered borrow.
- Sits downstream of operand registers and feeds the result/flag logic.
- Start/done handshake; trades WIDTH cycles of latency for a single-bit datapath.

---
 rtl/serial_subtractor.sv | 154 +++++++++++++++
 tb/tb_serial_subtractor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock.
// Single full-subtractor cell plus a registered borrow; start/done handshake.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start              : request, sampled only in IDLE
//   a, b, bin          : operands and borrow-in, captured on acceptance
//   busy               : high while bits are processed (WIDTH cycles)
//   done               : one-cycle pulse, result valid
//   diff, bout         : registered result and MSB borrow-out
//   ovf                : signed overflow (only with SERIAL_SUB_OVF_EN)
// Build option: define SERIAL_SUB_OVF_EN to add the ovf port and its logic.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_brw;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_brw_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_r_nxt;

  // Full-subtractor cell on the current LSBs.
  assign w_x       = r_a_sr[0];
  assign w_y       = r_b_sr[0];
  assign w_d       = w_x ^ w_y ^ r_brw;
  assign w_brw_nxt = (~w_x & w_y) | (w_y & r_brw) | (~w_x & r_brw);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  // Result bits enter at the MSB so the LSB ends up at bit 0.
  assign w_r_nxt   = {w_d, r_r_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_r_sr <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_brw  <= bin;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_r_sr <= w_r_nxt;
          r_brw  <= w_brw_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff <= w_r_nxt;
            r_bout <= w_brw_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // Borrow into the MSB is r_brw on the last bit; borrow out is w_brw_nxt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_ovf <= r_brw ^ w_brw_nxt;
    end
  end

  assign ovf = r_ovf;
`endif

  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, hand sequences and random ops
// against an arithmetic reference for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_prev;
  logic [W-1:0] got_diff;
  logic         got_bout;
  logic         got_ovf;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mbin, output logic [W-1:0] md,
                       output logic mbo, output logic mov);
    int u;
    int s;
    u   = int'(ma) - int'(mb) - int'(mbin);
    md  = W'(u);
    mbo = (u < 0);
    s   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    mov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
  endtask

  // One complete operation; checks handshake timing, output hold
  // during RUN, and leaves the captured result in got_*.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin);
    int busy_n;
    bit seen;
    bit hold_bad;
    @(negedge clk);
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    busy_n   = 0;
    seen     = 0;
    hold_bad = 0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_n++;
      if (diff !== exp_prev) hold_bad = 1;
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_cycles", busy_n, W);
    chk("diff_hold", 32'(hold_bad), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd0);
    got_diff = diff;
    got_bout = bout;
`ifdef SERIAL_SUB_OVF_EN
    got_ovf = ovf;
`else
    got_ovf = 1'b0;
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  vec_t vt[7];

  initial begin
    logic [W-1:0] md;
    logic         mbo;
    logic         mov;
    int           busy_n;
    bit           seen;

    vt[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
    vt[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vt[6] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    exp_prev = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].bin);
      chk($sformatf("vec%0d_diff", i), 32'(got_diff), 32'(vt[i].d));
      chk($sformatf("vec%0d_bout", i), 32'(got_bout), 32'(vt[i].bo));
      exp_prev = vt[i].d;
    end

    // start held through RUN and DONE must not queue a second op.
    @(negedge clk);
    a     = 8'h05;
    b     = 8'h03;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    a      = 8'hFF;
    b      = 8'h01;
    busy_n = 0;
    seen   = 0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_n++;
      @(negedge clk);
    end
    chk("b2b_done", 32'(seen), 32'd1);
    chk("b2b_busy_cycles", busy_n, W);
    chk("b2b_diff", 32'(diff), 32'h02);
    chk("b2b_bout", 32'(bout), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("b2b_no_launch", 32'(busy), 32'd0);
    chk("b2b_diff_held", 32'(diff), 32'h02);
    exp_prev = 8'h02;

    // Reset in the 4th RUN cycle aborts the op.
    a     = 8'hAA;
    b     = 8'h55;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_bout", 32'(bout), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done || busy) seen = 1;
      @(negedge clk);
    end
    chk("rst_no_done", 32'(seen), 32'd0);
    exp_prev = '0;
    run_op(8'h01, 8'h01, 1'b0);
    chk("post_rst_diff", 32'(got_diff), 32'h00);
    chk("post_rst_bout", 32'(got_bout), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0);
    chk("ovf1_diff", 32'(got_diff), 32'h7F);
    chk("ovf1_bout", 32'(got_bout), 32'd0);
    chk("ovf1_ovf", 32'(got_ovf), 32'd1);
    exp_prev = 8'h7F;
    run_op(8'h7F, 8'hFF, 1'b0);
    chk("ovf2_diff", 32'(got_diff), 32'h80);
    chk("ovf2_bout", 32'(got_bout), 32'd1);
    chk("ovf2_ovf", 32'(got_ovf), 32'd1);
    exp_prev = 8'h80;
    run_op(8'h05, 8'h03, 1'b0);
    chk("ovf3_ovf", 32'(got_ovf), 32'd0);
    exp_prev = 8'h02;
`endif

    for (int n = 0; n < 256; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      model(ra, rb, rbin, md, mbo, mov);
      run_op(ra, rb, rbin);
      chk("rand_diff", 32'(got_diff), 32'(md));
      chk("rand_bout", 32'(got_bout), 32'(mbo));
`ifdef SERIAL_SUB_OVF_EN
      chk("rand_ovf", 32'(got_ovf), 32'(mov));
`endif
      exp_prev = md;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
